// File: rtl/axis_stim_synth_if.sv
// AXI-Stream bundle for the stimulus source: tdata/tdest/tkeep/tlast/tvalid forward, tready back.
interface axis_stim_synth_if #(
  parameter int unsigned TDATA_NUM_BYTES = 8,
  parameter int unsigned TDEST_WIDTH     = 4
);
  logic [8*TDATA_NUM_BYTES-1:0] tdata;
  logic [TDEST_WIDTH-1:0]       tdest;
  logic [TDATA_NUM_BYTES-1:0]   tkeep;
  logic                         tlast;
  logic                         tvalid;
  logic                         tready;

  modport master (
    output tdata,
    output tdest,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tdest,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axis_stim_synth.sv
// AXI-Stream packet generator: tdata = {FIXED, byte counter}, fixed-length packets, single/cycle/cont.
// Optional AXIS_STIM_SYN_TDEST_CNT_EN: drive tdest from a per-packet counter instead of TDEST.
module axis_stim_synth #(
  parameter int unsigned                 TDATA_NUM_BYTES = 8,
  parameter logic [8*TDATA_NUM_BYTES-9:0] FIXED          = '0,
  parameter int unsigned                 PKT_LEN         = 16,
  parameter int unsigned                 GAP_CYCLES      = 16,
  parameter int unsigned                 TDEST_WIDTH     = 4,
  parameter logic [TDEST_WIDTH-1:0]      TDEST           = '0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              cycle_i,
  input  logic              cont_i,
  axis_stim_synth_if.master m_axis
);

  localparam int unsigned BeatW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(PKT_LEN - 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e           state_q, state_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [GapW-1:0]  gap_q, gap_d;

  logic             xfer;
  logic             load;
  logic [7:0]       cnt_c;
  logic [BeatW-1:0] beat_ld;

`ifdef AXIS_STIM_SYN_TDEST_CNT_EN
  logic [TDEST_WIDTH-1:0] pkt_q, pkt_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
`endif

  assign xfer  = tvalid_q & m_axis.tready;
  // cnt_q is the byte for the next beat to be loaded; a clear lands on that next load.
  assign cnt_c = clr_i ? 8'h00 : cnt_q;

  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    data_d   = data_q;
    cnt_d    = cnt_c;
    beat_d   = beat_q;
    gap_d    = gap_q;
    load     = 1'b0;
    beat_ld  = '0;

    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = StSend;
          load    = 1'b1;
        end
      end
      StSend: begin
        if (xfer) begin
          if (!tlast_q) begin
            load    = 1'b1;
            beat_ld = beat_q + BeatW'(1);
          end else if (!en_i) begin
            state_d = StIdle;
          end else if (cont_i || (cycle_i && GAP_CYCLES == 0)) begin
            load = 1'b1;
          end else if (cycle_i) begin
            state_d = StGap;
            gap_d   = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StGap: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (gap_q == GapLast) begin
          state_d = StSend;
          load    = 1'b1;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StDone: begin
        if (!en_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      tvalid_d = 1'b1;
      data_d   = cnt_c;
      cnt_d    = cnt_c + 8'd1;
      beat_d   = beat_ld;
      tlast_d  = (beat_ld == BeatLast);
    end else if (xfer) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      beat_d   = '0;
    end
  end

`ifdef AXIS_STIM_SYN_TDEST_CNT_EN
  always_comb begin
    pkt_d   = clr_i ? '0 : ((xfer && tlast_q) ? pkt_q + TDEST_WIDTH'(1) : pkt_q);
    // Latched only when a beat is loaded so tdest stays stable under stall.
    tdest_d = load ? pkt_d : tdest_q;
  end
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      data_q   <= 8'h00;
      cnt_q    <= 8'h00;
      beat_q   <= '0;
      gap_q    <= '0;
`ifdef AXIS_STIM_SYN_TDEST_CNT_EN
      pkt_q    <= '0;
      tdest_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
`ifdef AXIS_STIM_SYN_TDEST_CNT_EN
      pkt_q    <= pkt_d;
      tdest_q  <= tdest_d;
`endif
    end
  end

  assign m_axis.tdata  = {FIXED, data_q};
  assign m_axis.tkeep  = {TDATA_NUM_BYTES{tvalid_q}};
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tvalid = tvalid_q;
`ifdef AXIS_STIM_SYN_TDEST_CNT_EN
  assign m_axis.tdest  = tdest_q;
`else
  assign m_axis.tdest  = TDEST;
`endif

endmodule

// File: tb/tb_axis_stim_synth.sv
// Bench for axis_stim_synth: directed mode sequence, random tready, stream model of bytes/beats.
module tb_axis_stim_synth;
  localparam int unsigned N       = 8;
  localparam int unsigned PKT_LEN = 16;
  localparam int unsigned GAP     = 16;
  localparam int unsigned TDW     = 4;
  localparam logic [55:0] FIXED   = 56'h00AF_E600_0066_00;
  localparam logic [3:0]  TDEST_V = 4'hA;
  localparam logic [63:0] RST_DATA = 64'h00AF_E600_0066_0000;

  logic clk = 1'b0;
  logic rstn, en, clr, cycle, cont;
  always #5 clk = ~clk;

  axis_stim_synth_if #(.TDATA_NUM_BYTES(N), .TDEST_WIDTH(TDW)) m_axis ();

  axis_stim_synth #(
    .TDATA_NUM_BYTES(N),
    .FIXED          (FIXED),
    .PKT_LEN        (PKT_LEN),
    .GAP_CYCLES     (GAP),
    .TDEST_WIDTH    (TDW),
    .TDEST          (TDEST_V)
  ) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .en_i    (en),
    .clr_i   (clr),
    .cycle_i (cycle),
    .cont_i  (cont),
    .m_axis  (m_axis)
  );

  int vectors = 0;
  int miscompares = 0;

  // Stream model: byte of the presented/next beat, index within packet, totals.
  logic [7:0] cur;
  int   beat, xfers, pkts, low_run, gaps_checked;
  logic clr_after, prev_valid, check_gap, rand_ready, wrap_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur = 8'h00; beat = 0; clr_after = 1'b0; prev_valid = 1'b0; low_run = 0;
  endtask

  task automatic tick();
    logic v, r, c;
    v = m_axis.tvalid; r = m_axis.tready; c = clr;
    @(posedge clk);
    @(negedge clk);
    if (v && r) begin
      if (cur == 8'hFF && !c && !clr_after) wrap_seen = 1'b1;
      if (beat == PKT_LEN - 1) pkts++;
      xfers++;
      cur = (c || clr_after) ? 8'h00 : cur + 8'd1;
      clr_after = 1'b0;
      beat = (beat + 1) % PKT_LEN;
    end else if (c) begin
      if (v) clr_after = 1'b1;
      else cur = 8'h00;
    end
    if (v && !r) chk("hold_valid", m_axis.tvalid, 1);
    if (!m_axis.tvalid) begin
      low_run++;
    end else begin
      if (!prev_valid && check_gap) begin
        chk("gap_len", low_run, GAP);
        gaps_checked++;
      end
      low_run = 0;
    end
    prev_valid = m_axis.tvalid;
    if (m_axis.tvalid) begin
      chk("tdata", m_axis.tdata, {FIXED, cur});
      chk("tlast", m_axis.tlast, (beat == PKT_LEN - 1));
      chk("tkeep", m_axis.tkeep, 8'hFF);
      chk("tdest", m_axis.tdest, TDEST_V);
    end else begin
      chk("tkeep_idle", m_axis.tkeep, 8'h00);
      chk("tlast_idle", m_axis.tlast, 0);
    end
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n = 0;
    while (xfers < target && n < budget) begin
      if (rand_ready) m_axis.tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("xfer_budget", xfers, target);
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkts < target && n < budget) begin
      tick();
      n++;
    end
    chk("pkt_budget", pkts, target);
  endtask

  task automatic wait_beat(input int idx, input int budget);
    int n = 0;
    while (beat != idx && n < budget) begin
      tick();
      n++;
    end
    chk("reach_beat", beat, idx);
  endtask

  initial begin
    int lows;
    logic [7:0] held;
    rstn = 1'b1; en = 1'b0; clr = 1'b0; cycle = 1'b0; cont = 1'b0;
    m_axis.tready = 1'b0;
    xfers = 0; pkts = 0; gaps_checked = 0;
    check_gap = 1'b0; rand_ready = 1'b0; wrap_seen = 1'b0;
    model_reset();

    // Reset values, then idle with en low.
    #1 rstn = 1'b0;
    #1;
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tkeep", m_axis.tkeep, 0);
    chk("rst_tlast", m_axis.tlast, 0);
    chk("rst_tdata", m_axis.tdata, RST_DATA);
    chk("rst_tdest", m_axis.tdest, TDEST_V);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (5) begin
      tick();
      chk("idle_tvalid", m_axis.tvalid, 0);
      chk("idle_tdata", m_axis.tdata, RST_DATA);
    end

    // Single-shot packet behind a 100-cycle stall.
    en = 1'b1;
    tick();
    chk("en_latency", m_axis.tvalid, 1);
    repeat (99) tick();
    m_axis.tready = 1'b1;
    wait_xfers(16, 40);
    chk("first_pkt_count", pkts, 1);
    repeat (5) begin
      tick();
      chk("done_hold", m_axis.tvalid, 0);
    end

    // Re-arm via en low/high; en dropped mid-packet; random tready.
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    chk("rearm_valid", m_axis.tvalid, 1);
    en = 1'b0;
    rand_ready = 1'b1;
    wait_xfers(32, 300);
    rand_ready = 1'b0;
    m_axis.tready = 1'b1;
    repeat (5) begin
      tick();
      chk("idle_after_pkt2", m_axis.tvalid, 0);
    end
    chk("byte_after_pkt2", cur, 8'h20);

    // Cycle mode: exact gaps between packets.
    cycle = 1'b1;
    en = 1'b1;
    tick();
    check_gap = 1'b1;
    wait_pkts(pkts + 3, 150);
    chk("gaps_seen", gaps_checked >= 2, 1);

    // Continuous mode from the next boundary on: no bubbles, byte wraps.
    cont = 1'b1;
    cycle = 1'b0;
    wait_pkts(pkts + 1, 80);
    lows = 0;
    repeat (300) begin
      tick();
      if (!m_axis.tvalid) lows++;
    end
    chk("cont_bubbles", lows, 0);
    chk("byte_wrap_seen", wrap_seen, 1);

    // clr with a same-cycle transfer, then clr during a stall.
    wait_beat(5, 40);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_next_byte", m_axis.tdata[7:0], 8'h00);
    wait_pkts(pkts + 1, 40);
    m_axis.tready = 1'b0;
    tick();
    held = m_axis.tdata[7:0];
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();
    chk("stall_clr_hold", m_axis.tdata[7:0], held);
    m_axis.tready = 1'b1;
    tick();
    chk("stall_clr_next", m_axis.tdata[7:0], 8'h00);

    // Asynchronous reset mid-packet.
    check_gap = 1'b0;
    wait_beat(7, 40);
    #2 rstn = 1'b0;
    #1;
    chk("arst_tvalid", m_axis.tvalid, 0);
    chk("arst_tlast", m_axis.tlast, 0);
    chk("arst_tkeep", m_axis.tkeep, 0);
    chk("arst_tdata", m_axis.tdata, RST_DATA);
    model_reset();
    en = 1'b0;
    cont = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_idle", m_axis.tvalid, 0);
    en = 1'b1;
    tick();
    chk("post_rst_valid", m_axis.tvalid, 1);
    chk("post_rst_byte", m_axis.tdata[7:0], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_stim_synth.md
# axis_stim_synth

Synthesizable AXI-Stream stimulus source for bring-up and loopback testing. Emits packets of fixed length whose data word is a constant pattern concatenated with an incrementing byte counter. Sits at the head of an AXIS chain in place of a real data source, driven by simple static controls (enable, clear, cycle, continuous).

## Interface
- TDATA_NUM_BYTES, 8: tdata width in bytes (N ≥ 2).
- FIXED, 0: constant pattern, width 8*(N-1), placed in tdata[8N-1:8].
- PKT_LEN, 16: beats per packet (≥ 1); tlast on the final beat.
- GAP_CYCLES, 16: idle cycles between packets in cycle mode (≥ 0).
- TDEST_WIDTH, 4: tdest width.
- TDEST, 0: constant tdest value.
- clk  in  1  single clock; all logic rising-edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- en  in  1  enable generation.
- clr  in  1  synchronous clear of data and packet counters.
- cycle  in  1  repeat packets with GAP_CYCLES spacing.
- cont  in  1  repeat packets back-to-back (overrides cycle).
- M_AXIS_tdata  out  8N  {FIXED, cnt[7:0]}.
- M_AXIS_tdest  out  TDEST_WIDTH  destination.
- M_AXIS_tkeep  out  N  all ones while tvalid, else 0.
- M_AXIS_tlast  out  1  last beat of packet.
- M_AXIS_tready  in  1  downstream ready.
- M_AXIS_tvalid  out  1  beat valid.

## Operation
- Counters: cnt (8-bit payload, wraps 0xFF→0x00), beat (0..PKT_LEN-1), pkt (TDEST_WIDTH-bit packet count).
- Transfer = tvalid && tready. On transfer cnt++, beat++; beat wraps to 0 after tlast transfer, pkt++.
- States: IDLE, SEND, GAP, DONE.
- IDLE: tvalid=0. en=1 → SEND.
- SEND: tvalid=1. On tlast transfer: en=0 → IDLE; cont=1 → SEND (next packet, no bubble); cycle=1 → GAP; else → DONE.
- GAP: tvalid=0, counts GAP_CYCLES cycles (GAP_CYCLES=0 behaves as cont). en=0 → IDLE; count done → SEND.
- DONE (single-shot complete): tvalid=0; en=0 → IDLE. New packet requires en low then high.
- en deasserted mid-packet: packet completes; never drop tvalid before transfer.
- Stall: while tvalid && !tready, tdata/tlast/tdest/tkeep held stable.
- clr: zeroes cnt and pkt next cycle; beat index and state untouched; a pending (stalled) beat keeps its data, cleared value appears on the following beat. clr with a same-cycle transfer: clr wins (cnt=0).
- cycle/cont/clr sampled every cycle; mode change takes effect at next packet boundary decision.

## Timing
- Reset: tvalid=0, tlast=0, tkeep=0, tdata={FIXED,8'h00}, tdest=TDEST; cnt=beat=pkt=0; state IDLE.
- All outputs registered. en sampled high in IDLE → tvalid=1 on next edge (1-cycle latency).
- With tready=1 in SEND: one beat per cycle; cont gives 100% throughput across packets.
- Cycle mode: exactly GAP_CYCLES tvalid-low cycles between tlast transfer and next first beat.
- Reset mid-packet: outputs return to reset values immediately (asynchronous); partial packet abandoned.

## Configuration
- AXIS_STIM_SYN_TDEST_CNT_EN defined: M_AXIS_tdest = pkt counter (increments per packet, cleared by clr).
- Not defined: M_AXIS_tdest = TDEST constant; pkt counter removed.

## Test plan
(N=8, FIXED=56'h00AF_E600_0066_00, PKT_LEN=16, GAP_CYCLES=16)
- Reset, en=0 → tvalid=0, tkeep=0, tdata=64'h00AF_E600_0066_0000 throughout.
- en=1, tready=0 for 100 cycles → tvalid=1, tdata=64'h00AF_E600_0066_0000 stable; tready=1 → beats low byte 0x00..0x0F, tlast only on 0x0F, then tvalid=0 (DONE).
- Toggle en 0→1 (single-shot) → second packet low bytes 0x10..0x1F; tready randomly toggled → no beat lost/duplicated.
- cycle=1, en=1 → packets of 16 beats separated by exactly 16 tvalid-low cycles.
- cont=1, tready=1 → tvalid continuous, tlast every 16th cycle, low byte wraps 0xFF→0x00 after 256 beats.
- clr pulse mid-packet → next beat low byte 0x00, tlast still at packet beat 16; rstn low mid-packet → all outputs at reset values immediately.
